inst_loader: RTL and testbench
==============================

// Module: inst_loader
// PURPOSE
//   Boot-time program loader sitting directly upstream of the CPU's instruction-RAM write port.
//   Receives a byte stream (length header + program words), assembles big-endian 32-bit words,
//   and writes them to consecutive instruction-RAM addresses starting at PC_INITIAL.
//   Holds the CPU in reset/debug mode while loading, then releases it to run the program.
// PARAMETERS
//   PC_INITIAL     32'hbfc00000  first write address (CPU reset vector)
//   MAX_WORDS      1024          largest legal program length, in words
//   SETTLE_CYCLES  8             cycles between the last write and CPU release (1..255)
//   TIMEOUT        65535         idle cycles allowed between accepted bytes before ERROR
// PORTS
//   clk                     in   1   clock; all logic is on the rising edge
//   reset                   in   1   synchronous, active-high
//   start                   in   1   1-cycle pulse; begins a load (honoured in IDLE, RUN, ERROR)
//   in_valid                in   1   source byte valid
//   in_data                 in   8   source byte
//   in_ready                out  1   loader accepts the byte this cycle (in_valid & in_ready)
//   inst_ram_write_enable   out  1   1-cycle write strobe to instruction RAM
//   inst_ram_write_data     out  32  assembled word
//   inst_ram_write_address  out  32  byte address of the word
//   debug                   out  1   1 = CPU in load/debug mode
//   cpu_reset               out  1   1 = CPU held in reset
//   busy                    out  1   1 in LEN, DATA, SETTLE
//   done                    out  1   1 in RUN
//   error                   out  1   1 in ERROR
//   words_loaded            out  16  words written in the current load
// BEHAVIOUR
//   Reset: state=IDLE; debug=1, cpu_reset=1; in_ready, write_enable, busy, done, error=0;
//     write_data=0, write_address=PC_INITIAL, words_loaded=0, all internal counters=0.
//   All outputs are registered. in_ready is 1 only in LEN and DATA; the loader never stalls there.
//   IDLE: start -> LEN (byte_cnt=0, len=0, words_loaded=0).
//   LEN: each accepted byte shifts into len, MSB first. The 4th byte is checked on the next edge:
//     len==0 or len>MAX_WORDS -> ERROR; otherwise -> DATA with write_address preset to PC_INITIAL.
//   DATA: bytes shift into the word register, MSB first. The 4th byte of a word is accepted at edge t;
//     at t+1, write_enable=1 for exactly one cycle, with data and address presented that cycle.
//     - The first word is written at PC_INITIAL. After each write, the address increments by 4
//       (32-bit wrap) and words_loaded increments by 1.
//     - When the write of word len completes, in_ready=0 and the state goes to SETTLE.
//   SETTLE: debug=1, cpu_reset=1 for SETTLE_CYCLES cycles, then -> RUN.
//   RUN: debug=0, cpu_reset=0, done=1. Held until start (-> LEN) or reset.
//   ERROR: error=1, debug=1, cpu_reset=1, in_ready=0, write_enable=0. Held until start (-> LEN) or reset.
//   debug=1 and cpu_reset=1 in every state except RUN. On leaving RUN via start, both are 1 from the next cycle.
//   Timeout: in LEN or DATA, an idle counter clears on each accepted byte. Reaching TIMEOUT -> ERROR.
//   start in LEN, DATA or SETTLE is ignored.
//   Bytes presented while in_ready=0 are not consumed.
//   write_data and write_address hold their last value when write_enable=0.
//   reset mid-load: returns to IDLE with reset values on the next edge. A partial word is discarded, never written.
// TESTING
//   1. reset, start, stream 00 00 00 02 | 20 0F 0A F4 | 20 18 00 08 ->
//      write 200F0AF4@bfc00000, then 20180008@bfc00004; SETTLE 8 cycles; then debug=0, cpu_reset=0, done=1.
//   2. in_valid toggled pseudo-randomly during a 16-word load -> writes are exactly 16, addresses bfc00000..bfc0003c
//      in order, one write_enable pulse per word.
//   3. header 00 00 00 00, then separately header 00 00 04 01 (MAX_WORDS=1024) ->
//      ERROR, no write_enable, cpu_reset stays 1.
//   4. stop the stream after 6 of 8 data bytes for TIMEOUT cycles -> error=1, words_loaded=1;
//      start, full reload -> done=1.
//   5. assert reset after 2.5 words, then start and a 1-word stream ->
//      single write at bfc00000, words_loaded=1, no stale partial word.
//   6. start pulsed in DATA and in RUN -> ignored in DATA; in RUN, debug=1 and cpu_reset=1
//      the next cycle, and the reload begins at bfc00000.

Source files
------------

// File: rtl/inst_loader.sv
// Boot-time program loader: turns a length-prefixed big-endian byte stream into
// instruction-RAM word writes, holding the CPU in reset/debug until the program is in place.
module inst_loader #(
  parameter logic [31:0] PC_INITIAL    = 32'hbfc00000,
  parameter int unsigned MAX_WORDS     = 1024,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned TIMEOUT       = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        inst_ram_write_enable,
  output logic [31:0] inst_ram_write_data,
  output logic [31:0] inst_ram_write_address,
  output logic        debug,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_SETTLE,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [31:0] MAX_LEN     = 32'(MAX_WORDS);
  localparam logic [15:0] IDLE_LAST   = 16'(TIMEOUT - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      state, state_n;
  logic [31:0] len, len_n;
  logic [2:0]  byte_cnt, byte_cnt_n;
  logic [23:0] word_sr, word_sr_n;
  logic [15:0] idle_cnt, idle_cnt_n;
  logic [7:0]  settle_cnt, settle_cnt_n;
  logic [15:0] words_loaded_n;
  logic        in_ready_n;
  logic        we_n;
  logic [31:0] wdata_n;
  logic [31:0] waddr_n;
  logic        accept;
  logic        timed_out;
  logic        last_word;

  assign accept    = in_valid & in_ready;
  assign timed_out = (idle_cnt == IDLE_LAST);
  assign last_word = ({16'd0, words_loaded} + 32'd1) == len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= S_IDLE;
      len                    <= '0;
      byte_cnt               <= '0;
      word_sr                <= '0;
      idle_cnt               <= '0;
      settle_cnt             <= '0;
      words_loaded           <= '0;
      in_ready               <= 1'b0;
      inst_ram_write_enable  <= 1'b0;
      inst_ram_write_data    <= '0;
      inst_ram_write_address <= PC_INITIAL;
      debug                  <= 1'b1;
      cpu_reset              <= 1'b1;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      error                  <= 1'b0;
    end else begin
      state                  <= state_n;
      len                    <= len_n;
      byte_cnt               <= byte_cnt_n;
      word_sr                <= word_sr_n;
      idle_cnt               <= idle_cnt_n;
      settle_cnt             <= settle_cnt_n;
      words_loaded           <= words_loaded_n;
      in_ready               <= in_ready_n;
      inst_ram_write_enable  <= we_n;
      inst_ram_write_data    <= wdata_n;
      inst_ram_write_address <= waddr_n;
      debug                  <= (state_n != S_RUN);
      cpu_reset              <= (state_n != S_RUN);
      busy                   <= (state_n == S_LEN) || (state_n == S_DATA) || (state_n == S_SETTLE);
      done                   <= (state_n == S_RUN);
      error                  <= (state_n == S_ERROR);
    end
  end

  // Next-state and next-output logic; every output register is loaded from here,
  // so status flags always describe the state being entered.
  always_comb begin
    state_n        = state;
    len_n          = len;
    byte_cnt_n     = byte_cnt;
    word_sr_n      = word_sr;
    idle_cnt_n     = idle_cnt;
    settle_cnt_n   = settle_cnt;
    words_loaded_n = words_loaded;
    in_ready_n     = 1'b0;
    we_n           = 1'b0;
    wdata_n        = inst_ram_write_data;
    waddr_n        = inst_ram_write_address;

    if (inst_ram_write_enable) begin
      words_loaded_n = words_loaded + 16'd1;
    end

    case (state)
      S_LEN: begin
        in_ready_n = 1'b1;
        if (byte_cnt == 3'd4) begin
          byte_cnt_n = '0;
          idle_cnt_n = '0;
          if (len == 32'd0 || len > MAX_LEN) begin
            state_n    = S_ERROR;
            in_ready_n = 1'b0;
          end else begin
            state_n = S_DATA;
            waddr_n = PC_INITIAL;
          end
        end else if (accept) begin
          len_n      = {len[23:0], in_data};
          byte_cnt_n = byte_cnt + 3'd1;
          idle_cnt_n = '0;
          if (byte_cnt == 3'd3) begin
            in_ready_n = 1'b0;
          end
        end else if (timed_out) begin
          state_n    = S_ERROR;
          in_ready_n = 1'b0;
        end else begin
          idle_cnt_n = idle_cnt + 16'd1;
        end
      end

      // in_ready low while still in DATA marks the final word's write cycle.
      S_DATA: begin
        in_ready_n = 1'b1;
        if (!in_ready) begin
          in_ready_n   = 1'b0;
          state_n      = S_SETTLE;
          settle_cnt_n = '0;
        end else if (accept) begin
          word_sr_n  = {word_sr[15:0], in_data};
          byte_cnt_n = byte_cnt + 3'd1;
          idle_cnt_n = '0;
          if (byte_cnt == 3'd3) begin
            byte_cnt_n = '0;
            we_n       = 1'b1;
            wdata_n    = {word_sr, in_data};
            if (words_loaded != 16'd0) begin
              waddr_n = inst_ram_write_address + 32'd4;
            end
            if (last_word) begin
              in_ready_n = 1'b0;
            end
          end
        end else if (timed_out) begin
          state_n    = S_ERROR;
          in_ready_n = 1'b0;
        end else begin
          idle_cnt_n = idle_cnt + 16'd1;
        end
      end

      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_n = S_RUN;
        end else begin
          settle_cnt_n = settle_cnt + 8'd1;
        end
      end

      default: begin
      end
    endcase

    if ((state == S_IDLE || state == S_RUN || state == S_ERROR) && start) begin
      state_n        = S_LEN;
      len_n          = '0;
      byte_cnt_n     = '0;
      word_sr_n      = '0;
      idle_cnt_n     = '0;
      words_loaded_n = '0;
      in_ready_n     = 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: table of whole-load vectors plus hand-written
// sequences for settle timing, timeout, mid-load reset and start handling.
module tb_inst_loader;

  localparam int T_OUT  = 300;
  localparam int SETTLE = 8;
  localparam logic [31:0] PC0 = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        inst_ram_write_enable;
  logic [31:0] inst_ram_write_data;
  logic [31:0] inst_ram_write_address;
  logic        debug;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t wr_q[$];

  typedef struct {
    string name;
    int    len_hdr;
    bit    gaps;
    bit    exp_err;
  } vec_t;
  vec_t vecs[6];

  inst_loader #(
    .PC_INITIAL   (PC0),
    .MAX_WORDS    (1024),
    .SETTLE_CYCLES(SETTLE),
    .TIMEOUT      (T_OUT)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .in_valid              (in_valid),
    .in_data               (in_data),
    .in_ready              (in_ready),
    .inst_ram_write_enable (inst_ram_write_enable),
    .inst_ram_write_data   (inst_ram_write_data),
    .inst_ram_write_address(inst_ram_write_address),
    .debug                 (debug),
    .cpu_reset             (cpu_reset),
    .busy                  (busy),
    .done                  (done),
    .error                 (error),
    .words_loaded          (words_loaded)
  );

  always #5 clk = ~clk;

  // Log every RAM write, sampled on the falling edge.
  always @(negedge clk) begin
    if (inst_ram_write_enable === 1'b1) begin
      wr_q.push_back({inst_ram_write_address, inst_ram_write_data});
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int v, input int i);
    return 32'h5A00_0000 ^ (32'(v) << 20) ^ (32'(i) * 32'h0001_0003);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checkOutput("in_ready_seen", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 3; k >= 0; k--) begin
      send_byte(w[8*k +: 8], gaps);
    end
  endtask

  task automatic wait_end(input int bound);
    int n = 0;
    while (!(done || error) && n < bound) begin
      tick();
      n++;
    end
    checkOutput("end_reached", {31'd0, done | error}, 32'd1);
  endtask

  task automatic check_writes(input string name, input int v, input int n);
    checkOutput({name, ":write_count"}, 32'(wr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      checkOutput({name, ":addr"}, wr_q[i].addr, PC0 + 32'(4 * i));
      checkOutput({name, ":data"}, wr_q[i].data, word_of(v, i));
    end
  endtask

  // One complete load from start pulse to done/error, then the final status.
  task automatic applyStimulus(input int v, input vec_t vec);
    int nw;
    nw = vec.exp_err ? 0 : vec.len_hdr;
    wr_q.delete();
    pulse_start();
    send_word(32'(vec.len_hdr), vec.gaps);
    for (int i = 0; i < nw; i++) begin
      send_word(word_of(v, i), vec.gaps);
    end
    wait_end(T_OUT + 50);
    checkOutput({vec.name, ":error"}, {31'd0, error}, {31'd0, vec.exp_err});
    checkOutput({vec.name, ":done"}, {31'd0, done}, {31'd0, !vec.exp_err});
    checkOutput({vec.name, ":cpu_reset"}, {31'd0, cpu_reset}, {31'd0, vec.exp_err});
    checkOutput({vec.name, ":debug"}, {31'd0, debug}, {31'd0, vec.exp_err});
    checkOutput({vec.name, ":words_loaded"}, {16'd0, words_loaded}, 32'(nw));
    check_writes(vec.name, v, nw);
  endtask

  initial begin
    int cycles;
    bit held;

    vecs[0] = '{"len1",       1,    1'b0, 1'b0};
    vecs[1] = '{"len3",       3,    1'b0, 1'b0};
    vecs[2] = '{"len16_gaps", 16,   1'b1, 1'b0};
    vecs[3] = '{"len0",       0,    1'b0, 1'b1};
    vecs[4] = '{"len1025",    1025, 1'b0, 1'b1};
    vecs[5] = '{"len1024",    1024, 1'b0, 1'b0};

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rst:debug", {31'd0, debug}, 32'd1);
    checkOutput("rst:cpu_reset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("rst:in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst:we", {31'd0, inst_ram_write_enable}, 32'd0);
    checkOutput("rst:busy", {31'd0, busy}, 32'd0);
    checkOutput("rst:done", {31'd0, done}, 32'd0);
    checkOutput("rst:error", {31'd0, error}, 32'd0);
    checkOutput("rst:wdata", inst_ram_write_data, 32'd0);
    checkOutput("rst:waddr", inst_ram_write_address, PC0);
    checkOutput("rst:words", {16'd0, words_loaded}, 32'd0);

    $display("[TB] two-word load with settle timing");
    wr_q.delete();
    pulse_start();
    checkOutput("t1:busy", {31'd0, busy}, 32'd1);
    checkOutput("t1:in_ready", {31'd0, in_ready}, 32'd1);
    send_word(32'd2, 1'b0);
    send_word(32'h200F0AF4, 1'b0);
    checkOutput("t1:we0", {31'd0, inst_ram_write_enable}, 32'd1);
    checkOutput("t1:data0", inst_ram_write_data, 32'h200F0AF4);
    checkOutput("t1:addr0", inst_ram_write_address, PC0);
    tick();
    checkOutput("t1:we0_off", {31'd0, inst_ram_write_enable}, 32'd0);
    checkOutput("t1:data0_hold", inst_ram_write_data, 32'h200F0AF4);
    checkOutput("t1:words1", {16'd0, words_loaded}, 32'd1);
    send_word(32'h20180008, 1'b0);
    checkOutput("t1:we1", {31'd0, inst_ram_write_enable}, 32'd1);
    checkOutput("t1:data1", inst_ram_write_data, 32'h20180008);
    checkOutput("t1:addr1", inst_ram_write_address, 32'hbfc00004);
    cycles = 0;
    held   = 1'b1;
    while (!done && cycles < 50) begin
      tick();
      cycles++;
      if (!done && !(cpu_reset && debug && busy)) held = 1'b0;
    end
    checkOutput("t1:settle_cycles", 32'(cycles), 32'(SETTLE + 1));
    checkOutput("t1:held_in_settle", {31'd0, held}, 32'd1);
    checkOutput("t1:debug_run", {31'd0, debug}, 32'd0);
    checkOutput("t1:cpu_reset_run", {31'd0, cpu_reset}, 32'd0);
    checkOutput("t1:busy_run", {31'd0, busy}, 32'd0);
    checkOutput("t1:words2", {16'd0, words_loaded}, 32'd2);
    checkOutput("t1:write_count", 32'(wr_q.size()), 32'd2);

    for (int v = 0; v < 6; v++) begin
      $display("[TB] vector %s", vecs[v].name);
      applyStimulus(v, vecs[v]);
    end

    $display("[TB] timeout after 6 of 8 data bytes");
    wr_q.delete();
    pulse_start();
    send_word(32'd2, 1'b0);
    send_word(word_of(9, 0), 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    cycles = 0;
    while (!error && cycles < T_OUT + 50) begin
      tick();
      cycles++;
    end
    checkOutput("to:cycles", 32'(cycles), 32'(T_OUT));
    checkOutput("to:error", {31'd0, error}, 32'd1);
    checkOutput("to:words", {16'd0, words_loaded}, 32'd1);
    checkOutput("to:cpu_reset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("to:in_ready", {31'd0, in_ready}, 32'd0);
    check_writes("to", 9, 1);
    applyStimulus(9, '{"to_reload", 2, 1'b0, 1'b0});

    $display("[TB] reset mid-load");
    pulse_start();
    send_word(32'd3, 1'b0);
    send_word(word_of(7, 0), 1'b0);
    send_word(word_of(7, 1), 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    reset = 1'b1;
    tick();
    checkOutput("mr:busy", {31'd0, busy}, 32'd0);
    checkOutput("mr:in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("mr:words", {16'd0, words_loaded}, 32'd0);
    checkOutput("mr:waddr", inst_ram_write_address, PC0);
    checkOutput("mr:wdata", inst_ram_write_data, 32'd0);
    reset = 1'b0;
    tick();
    applyStimulus(11, '{"mr_reload", 1, 1'b0, 1'b0});

    $display("[TB] start ignored in DATA, honoured in RUN");
    wr_q.delete();
    pulse_start();
    send_word(32'd2, 1'b0);
    send_word(word_of(12, 0), 1'b0);
    send_byte(word_of(12, 1) >> 24, 1'b0);
    send_byte(word_of(12, 1) >> 16, 1'b0);
    pulse_start();
    checkOutput("sd:busy", {31'd0, busy}, 32'd1);
    send_byte(word_of(12, 1) >> 8, 1'b0);
    send_byte(word_of(12, 1), 1'b0);
    wait_end(50);
    checkOutput("sd:done", {31'd0, done}, 32'd1);
    checkOutput("sd:words", {16'd0, words_loaded}, 32'd2);
    check_writes("sd", 12, 2);
    wr_q.delete();
    pulse_start();
    checkOutput("sr:debug", {31'd0, debug}, 32'd1);
    checkOutput("sr:cpu_reset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("sr:done", {31'd0, done}, 32'd0);
    checkOutput("sr:busy", {31'd0, busy}, 32'd1);
    send_word(32'd1, 1'b0);
    send_word(word_of(13, 0), 1'b0);
    wait_end(50);
    checkOutput("sr:done_end", {31'd0, done}, 32'd1);
    check_writes("sr", 13, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
